// File: rtl/sensor_responder.sv
// Sensor-side UART endpoint: receives an addressed command byte and answers with
// a data byte followed by its CRC-8, driving the shared return line only while replying.
module sensor_responder #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter logic [7:0]  KEY          = 8'b00110111,
    parameter logic [2:0]  NODE_ADDR    = 3'd1,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rx,
    input  logic [7:0] sample,
    output logic       tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned CntMax    = (GapCycles > CLKS_PER_BIT) ? GapCycles : CLKS_PER_BIT;
    localparam int unsigned CntW      = $clog2(CntMax + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RX_START = 3'd1;
    localparam logic [2:0] ST_RX_DATA  = 3'd2;
    localparam logic [2:0] ST_RX_STOP  = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_TX_DATA  = 3'd5;
    localparam logic [2:0] ST_TX_CRC   = 3'd6;
    localparam logic [2:0] ST_RX_ERR   = 3'd7;

    localparam logic [4:0] OP_READ = 5'h01;
    localparam logic [4:0] OP_PING = 5'h02;

    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ KEY) : (c << 1);
        end
        return c;
    endfunction

    // Bit 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] k;
        k = idx - 4'd1;
        if (idx == 4'd0) return 1'b0;
        else if (idx >= 4'd9) return 1'b1;
        else return b[k[2:0]];
    endfunction

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      crc_q, crc_d;
    logic            tx_q, tx_d;
    logic            tx_oe_q, tx_oe_d;
    logic            busy_q, busy_d;
    logic            cmd_err_q, cmd_err_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;

    logic            bit_tick;
    logic            cmd_valid;
    logic [7:0]      reply_byte;
    logic [7:0]      tx_byte;

    assign bit_tick   = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign cmd_valid  = (shift_q[7:5] == NODE_ADDR) &&
                        ((shift_q[4:0] == OP_READ) || (shift_q[4:0] == OP_PING));
    assign reply_byte = (shift_q[4:0] == OP_READ) ? sample : {5'b0, NODE_ADDR};
    assign tx_byte    = (state_q == ST_TX_DATA) ? data_q : crc_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CntW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        crc_d     = crc_q;
        tx_d      = tx_q;
        tx_oe_d   = tx_oe_q;
        busy_d    = busy_q;
        cmd_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = ST_RX_START;
                end
            end
            ST_RX_START: begin
                if (clk_cnt_q == CntW'(CLKS_PER_BIT / 2 - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync_q ? ST_IDLE : ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = ST_RX_STOP;
                    end
                end
            end
            ST_RX_STOP: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    if (!rx_sync_q) begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_RX_ERR;
                    end else if (cmd_valid) begin
                        data_d  = reply_byte;
                        crc_d   = crc8(reply_byte);
                        busy_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RX_ERR: begin
                clk_cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (clk_cnt_q == CntW'(GapCycles - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    tx_oe_d   = 1'b1;
                    state_d   = ST_TX_DATA;
                end
            end
            ST_TX_DATA, ST_TX_CRC: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        bit_cnt_d = '0;
                        if (state_q == ST_TX_DATA) begin
                            // CRC frame starts immediately after the data stop bit.
                            tx_d    = 1'b0;
                            state_d = ST_TX_CRC;
                        end else begin
                            tx_d    = 1'b1;
                            tx_oe_d = 1'b0;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = frame_bit(tx_byte, bit_cnt_q + 4'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            crc_q     <= '0;
            tx_q      <= 1'b1;
            tx_oe_q   <= 1'b0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            tx_q      <= tx_d;
            tx_oe_q   <= tx_oe_d;
            busy_q    <= busy_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign tx      = tx_q;
    assign tx_oe   = tx_oe_q;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder: drives UART commands and decodes the two-byte reply.
module tb_sensor_responder;

    localparam int CPB = 16;

    logic       clock;
    logic       resetn;
    logic       rx;
    logic [7:0] sample;
    logic       tx;
    logic       tx_oe;
    logic       busy;
    logic       cmd_err;

    int n_cmp;
    int n_fail;

    sensor_responder #(
        .CLKS_PER_BIT(CPB),
        .KEY         (8'b00110111),
        .NODE_ADDR   (3'd1),
        .GAP_BITS    (2)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .rx     (rx),
        .sample (sample),
        .tx     (tx),
        .tx_oe  (tx_oe),
        .busy   (busy),
        .cmd_err(cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clock);
        end
        rx = 1'b1;
    endtask

    // Waits for busy, then tx_oe, and decodes the 20 reply bits at mid-bit.
    task automatic get_reply(output logic [7:0] d, output logic [7:0] c, output int offset,
                             output int len, output logic fr_ok, output logic got);
        logic [19:0] bits;
        logic        last_busy;
        int          t;
        got = 1'b0; d = '0; c = '0; offset = 0; len = 0; fr_ok = 1'b0;
        bits = '0; last_busy = 1'b0; t = 0;
        while (busy !== 1'b1 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (busy !== 1'b1) return;
        while (tx_oe !== 1'b1 && offset < 1000) begin
            @(negedge clock);
            offset++;
        end
        if (tx_oe !== 1'b1) return;
        while (tx_oe === 1'b1 && len < 400) begin
            if ((len % CPB) == CPB / 2 && (len / CPB) < 20) bits[len / CPB] = tx;
            last_busy = busy;
            @(negedge clock);
            len++;
        end
        fr_ok = (bits[0] == 1'b0) && (bits[9] == 1'b1) && (bits[10] == 1'b0) &&
                (bits[19] == 1'b1) && (last_busy === 1'b1) && (busy === 1'b0) && (tx === 1'b1);
        d   = bits[8:1];
        c   = bits[18:11];
        got = 1'b1;
    endtask

    task automatic watch_quiet(input int cycles, output int bad);
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || tx_oe !== 1'b0 || busy !== 1'b0) bad++;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        rx     = 1'b1;
        sample = 8'h00;
        repeat (3) @(negedge clock);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx); end
        n_cmp++; if (tx_oe !== 1'b0) begin n_fail++; $display("FAIL reset_tx_oe got=%b exp=0", tx_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        resetn = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_read;
        logic [7:0] d, c;
        int         off, len;
        logic       fr, got;
        sample = 8'h80;
        fork
            send_byte(8'h21, 1'b1);
            get_reply(d, c, off, len, fr, got);
        join
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL read_got got=%b exp=1", got); end
        n_cmp++; if (d !== 8'h80) begin n_fail++; $display("FAIL read_data got=%h exp=80", d); end
        n_cmp++; if (c !== 8'h7F) begin n_fail++; $display("FAIL read_crc got=%h exp=7f", c); end
        n_cmp++; if (off != 32) begin n_fail++; $display("FAIL read_offset got=%0d exp=32", off); end
        n_cmp++; if (len != 320) begin n_fail++; $display("FAIL read_window got=%0d exp=320", len); end
        n_cmp++; if (fr !== 1'b1) begin n_fail++; $display("FAIL read_framing got=%b exp=1", fr); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_ping;
        logic [7:0] d, c;
        int         off, len;
        logic       fr, got;
        fork
            send_byte(8'h22, 1'b1);
            get_reply(d, c, off, len, fr, got);
        join
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL ping_data got=%h exp=01", d); end
        n_cmp++; if (c !== 8'h37) begin n_fail++; $display("FAIL ping_crc got=%h exp=37", c); end
        n_cmp++; if (fr !== 1'b1) begin n_fail++; $display("FAIL ping_framing got=%b exp=1", fr); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_drop;
        int bad;
        fork
            send_byte(8'h41, 1'b1);
            watch_quiet(400, bad);
        join
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drop_addr got=%0d active cycles exp=0", bad); end
        fork
            send_byte(8'h3F, 1'b1);
            watch_quiet(400, bad);
        join
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drop_opcode got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_frame_err;
        int         err_cycles, oe_cycles;
        logic [7:0] d, c;
        int         off, len;
        logic       fr, got;
        err_cycles = 0;
        oe_cycles  = 0;
        fork
            send_byte(8'h21, 1'b0);
            for (int i = 0; i < 400; i++) begin
                @(negedge clock);
                if (cmd_err === 1'b1) err_cycles++;
                if (tx_oe !== 1'b0 || busy !== 1'b0) oe_cycles++;
            end
        join
        n_cmp++; if (err_cycles != 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d exp=1", err_cycles); end
        n_cmp++; if (oe_cycles != 0) begin n_fail++; $display("FAIL ferr_noreply got=%0d exp=0", oe_cycles); end
        sample = 8'h80;
        fork
            send_byte(8'h21, 1'b1);
            get_reply(d, c, off, len, fr, got);
        join
        n_cmp++; if (d !== 8'h80 || c !== 8'h7F) begin
            n_fail++; $display("FAIL ferr_recover got=%h/%h exp=80/7f", d, c);
        end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_glitch;
        int bad, rxdata;
        bad    = 0;
        rxdata = 0;
        @(posedge clock);
        rx = 1'b0;
        repeat (4) @(posedge clock);
        rx = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (dut.state_q === 3'd2) rxdata++;
            if (tx !== 1'b1 || tx_oe !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (rxdata != 0) begin n_fail++; $display("FAIL glitch_rxdata got=%0d exp=0", rxdata); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL glitch_quiet got=%0d exp=0", bad); end
    endtask

    task automatic test_latch;
        logic [7:0] d, c;
        int         off, len;
        logic       fr, got;
        sample = 8'h80;
        fork
            send_byte(8'h21, 1'b1);
            get_reply(d, c, off, len, fr, got);
            begin
                for (int i = 0; i < 400 && busy !== 1'b1; i++) @(negedge clock);
                repeat (5) @(negedge clock);
                sample = 8'h55;
            end
        join
        n_cmp++; if (d !== 8'h80) begin n_fail++; $display("FAIL latch_data got=%h exp=80", d); end
        n_cmp++; if (c !== 8'h7F) begin n_fail++; $display("FAIL latch_crc got=%h exp=7f", c); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_cmd_during_reply;
        logic [7:0] d, c;
        int         off, len, bad;
        logic       fr, got;
        sample = 8'h80;
        fork
            send_byte(8'h21, 1'b1);
            get_reply(d, c, off, len, fr, got);
            begin
                for (int i = 0; i < 600 && tx_oe !== 1'b1; i++) @(negedge clock);
                repeat (20) @(negedge clock);
                send_byte(8'h22, 1'b1);
            end
        join
        n_cmp++; if (d !== 8'h80 || c !== 8'h7F || fr !== 1'b1) begin
            n_fail++; $display("FAIL overlap_reply got=%h/%h fr=%b exp=80/7f fr=1", d, c, fr);
        end
        watch_quiet(400, bad);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL overlap_ignored got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d, c;
        int         off, len, t;
        logic       fr, got;
        sample = 8'hFF;
        send_byte(8'h21, 1'b1);
        t = 0;
        while (tx_oe !== 1'b1 && t < 400) begin
            @(posedge clock);
            t++;
        end
        n_cmp++; if (tx_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_start got=%b exp=1", tx_oe); end
        repeat (3 * CPB + CPB / 2) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || tx_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs got=%b%b%b exp=100", tx, tx_oe, busy);
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        fork
            send_byte(8'h21, 1'b1);
            get_reply(d, c, off, len, fr, got);
        join
        n_cmp++; if (d !== 8'hFF) begin n_fail++; $display("FAIL rstmid_data got=%h exp=ff", d); end
        n_cmp++; if (c !== 8'hAA) begin n_fail++; $display("FAIL rstmid_crc got=%h exp=aa", c); end
        n_cmp++; if (fr !== 1'b1 || len != 320) begin
            n_fail++; $display("FAIL rstmid_frame got=fr%b len%0d exp=fr1 len320", fr, len);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_read();
        test_ping();
        test_drop();
        test_frame_err();
        test_glitch();
        test_latch();
        test_cmd_during_reply();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
